vga_plot_arbiter: RTL and testbench

- Shares the single pixel-write port of vga_adapter (x/y/colour/plot) between N_REQ independent requesters.
- Typical requesters: the 28x28 grid renderer, a classification-result overlay, and a screen-clear engine.
- Arbitration is round-robin with burst locking, so a requester's whole 4x4 cell write, or longer run, is never interleaved with another requester's.
- Off-screen coordinates are clipped, and the output port is registered.

---
 rtl/vga_pkg.sv | 12 +
 rtl/vga_plot_arbiter_if.sv | 22 ++
 rtl/rr_select.sv | 28 ++
 rtl/vga_plot_arbiter.sv | 136 +++++++++++++
 tb/tb_vga_plot_arbiter.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA geometry, colour codes and plot-arbiter state encoding.
package vga_pkg;
   localparam int VGA_X_MAX = 160;
   localparam int VGA_Y_MAX = 120;
   localparam int VGA_XW = 8;
   localparam int VGA_YW = 7;
   localparam int VGA_CW = 3;
   localparam logic [VGA_CW-1:0] COL_BG = 3'b001;
   localparam logic [VGA_CW-1:0] COL_CURSOR = 3'b100;
   localparam logic [VGA_CW-1:0] COL_SET = 3'b111;
   typedef enum logic {S_IDLE = 1'b0, S_OWN = 1'b1} arb_state_t;
endpackage

// File: rtl/vga_plot_arbiter_if.sv
// vga_plot_arbiter_if: packed requester bus plus the shared vga_adapter write port.
interface vga_plot_arbiter_if
   import vga_pkg::*;
#(
   parameter int N_REQ = 2
) ();
   logic [N_REQ-1:0]        req;
   logic [N_REQ-1:0]        req_last;
   logic [VGA_XW*N_REQ-1:0] req_x;
   logic [VGA_YW*N_REQ-1:0] req_y;
   logic [VGA_CW*N_REQ-1:0] req_colour;
   logic [N_REQ-1:0]        gnt;
   logic                    plot;
   logic [VGA_XW-1:0]       x;
   logic [VGA_YW-1:0]       y;
   logic [VGA_CW-1:0]       colour;
   logic                    busy;
   modport master (output req, req_last, req_x, req_y, req_colour,
                   input gnt, plot, x, y, colour, busy);
   modport slave (input req, req_last, req_x, req_y, req_colour,
                  output gnt, plot, x, y, colour, busy);
endinterface

// File: rtl/rr_select.sv
// rr_select: combinational round-robin pick, first set bit searching upward from i_ptr+1.
module rr_select #(
   parameter int N = 2,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_pick,
   output logic [IW-1:0] o_idx
);
   int w_best;
   int w_dist;
   always_comb begin
      w_best = N;
      w_dist = 0;
      o_idx = '0;
      o_pick = '0;
      for (int p = 0; p < N; p++) begin
         w_dist = (p - int'(i_ptr) - 1 + 2 * N) % N;
         if (i_req[p] && w_dist < w_best) begin
            w_best = w_dist;
            o_idx = IW'(p);
         end
      end
      for (int p = 0; p < N; p++)
         o_pick[p] = (w_best < N) && (o_idx == IW'(p));
   end
endmodule

// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: round-robin, burst-locked sharing of the vga_adapter pixel port with clipping.
// Optional per-requester beat and clipped-beat counters under VGA_PLOT_ARB_STATS_EN.
module vga_plot_arbiter
   import vga_pkg::*;
#(
   parameter int N_REQ = 2,
   parameter int X_MAX = VGA_X_MAX,
   parameter int Y_MAX = VGA_Y_MAX,
   parameter int BURST_MAX = 64
) (
   input logic clk,
   input logic reset,
   vga_plot_arbiter_if.slave bus
`ifdef VGA_PLOT_ARB_STATS_EN
   ,
   output logic [16*N_REQ-1:0] stat_beats,
   output logic [15:0]         stat_clipped
`endif
);
   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   arb_state_t        r_state;
   logic [IW-1:0]     r_owner;
   logic [IW-1:0]     r_ptr;
   logic [7:0]        r_beat;
   logic [N_REQ-1:0]  r_gnt;
   logic              r_plot;
   logic              r_busy;
   logic [VGA_XW-1:0] r_x;
   logic [VGA_YW-1:0] r_y;
   logic [VGA_CW-1:0] r_colour;

   logic [N_REQ-1:0]  w_pick;
   logic [IW-1:0]     w_idx;
   logic              w_acc;
   logic              w_last;
   logic [VGA_XW-1:0] w_x;
   logic [VGA_YW-1:0] w_y;
   logic [VGA_CW-1:0] w_colour;
   logic              w_clip;
   logic              w_force;
   logic              w_rel;

   rr_select #(.N(N_REQ), .IW(IW)) u_rr (
      .i_req  (bus.req),
      .i_ptr  (r_ptr),
      .o_pick (w_pick),
      .o_idx  (w_idx)
   );

   always_comb begin
      w_acc = 1'b0;
      w_last = 1'b0;
      w_x = '0;
      w_y = '0;
      w_colour = '0;
      for (int p = 0; p < N_REQ; p++)
         if (r_owner == IW'(p)) begin
            w_acc = bus.req[p];
            w_last = bus.req_last[p];
            w_x = bus.req_x[VGA_XW*p +: VGA_XW];
            w_y = bus.req_y[VGA_YW*p +: VGA_YW];
            w_colour = bus.req_colour[VGA_CW*p +: VGA_CW];
         end
      w_clip = (int'(w_x) >= X_MAX) || (int'(w_y) >= Y_MAX);
      w_force = ({1'b0, r_beat} + 9'd1) == 9'(BURST_MAX);
      // dropping req while owning abandons the burst, so any idle cycle also releases
      w_rel = !w_acc || w_last || w_force;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_owner <= '0;
         r_ptr <= IW'(N_REQ - 1);
         r_beat <= '0;
         r_gnt <= '0;
         r_plot <= 1'b0;
         r_busy <= 1'b0;
         r_x <= '0;
         r_y <= '0;
         r_colour <= '0;
      end else if (r_state == S_IDLE) begin
         r_plot <= 1'b0;
         if (|bus.req) begin
            r_gnt <= w_pick;
            r_owner <= w_idx;
            r_beat <= '0;
            r_busy <= 1'b1;
            r_state <= S_OWN;
         end
      end else begin
         r_plot <= w_acc && !w_clip;
         if (w_acc) begin
            r_x <= w_x;
            r_y <= w_y;
            r_colour <= w_colour;
            r_beat <= (r_beat == 8'(BURST_MAX)) ? r_beat : r_beat + 8'd1;
         end
         if (w_rel) begin
            r_gnt <= '0;
            r_busy <= 1'b0;
            r_ptr <= r_owner;
            r_state <= S_IDLE;
         end
      end
   end

   assign bus.gnt = r_gnt;
   assign bus.plot = r_plot;
   assign bus.x = r_x;
   assign bus.y = r_y;
   assign bus.colour = r_colour;
   assign bus.busy = r_busy;

`ifdef VGA_PLOT_ARB_STATS_EN
   logic [16*N_REQ-1:0] r_stat_beats;
   logic [15:0]         r_stat_clipped;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stat_beats <= '0;
         r_stat_clipped <= '0;
      end else if (r_state == S_OWN && w_acc) begin
         for (int p = 0; p < N_REQ; p++)
            if (r_owner == IW'(p))
               r_stat_beats[16*p +: 16] <= r_stat_beats[16*p +: 16] + 16'd1;
         if (w_clip && r_stat_clipped != 16'hFFFF)
            r_stat_clipped <= r_stat_clipped + 16'd1;
      end
   end

   assign stat_beats = r_stat_beats;
   assign stat_clipped = r_stat_clipped;
`endif
endmodule

// File: tb/tb_vga_plot_arbiter.sv
// tb_vga_plot_arbiter: randomized requesters checked cycle by cycle against a transaction-level arbiter model.
module tb_vga_plot_arbiter;
   localparam int N = 3;
   localparam int XM = 160;
   localparam int YM = 120;
   localparam int BM = 8;

   typedef struct {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] c;
      bit         last;
   } beat_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   vga_plot_arbiter_if #(.N_REQ(N)) bus ();
`ifdef VGA_PLOT_ARB_STATS_EN
   logic [16*N-1:0] stat_beats;
   logic [15:0]     stat_clipped;
   vga_plot_arbiter #(.N_REQ(N), .X_MAX(XM), .Y_MAX(YM), .BURST_MAX(BM)) dut (
      .clk(clk), .reset(reset), .bus(bus),
      .stat_beats(stat_beats), .stat_clipped(stat_clipped));
   int m_sb [N];
   int m_sc;
`else
   vga_plot_arbiter #(.N_REQ(N), .X_MAX(XM), .Y_MAX(YM), .BURST_MAX(BM)) dut (
      .clk(clk), .reset(reset), .bus(bus));
`endif

   int checks = 0;
   int errors = 0;
   bit gen_en = 0;

   beat_t bq [N][16];
   int    bh [N];
   int    bn [N];

   int         m_owner, m_ptr, m_beats;
   logic [N-1:0] e_gnt;
   logic       e_plot, e_busy;
   logic [7:0] e_x;
   logic [6:0] e_y;
   logic [2:0] e_c;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_ptr = N - 1;
      m_beats = 0;
      e_gnt = '0;
      e_plot = 0;
      e_busy = 0;
      e_x = 0;
      e_y = 0;
      e_c = 0;
      for (int i = 0; i < N; i++) begin
         bh[i] = 0;
         bn[i] = 0;
      end
`ifdef VGA_PLOT_ARB_STATS_EN
      for (int i = 0; i < N; i++) m_sb[i] = 0;
      m_sc = 0;
`endif
   endtask

   task automatic put(input int i, input int j, input int x, input int y, input int c, input bit last);
      bq[i][j].x = 8'(x);
      bq[i][j].y = 7'(y);
      bq[i][j].c = 3'(c);
      bq[i][j].last = last;
   endtask

   task automatic new_burst(input int i, input int len, input bit with_last);
      int sx, sy;
      for (int j = 0; j < len; j++) begin
         sx = $urandom_range(0, 7);
         sy = $urandom_range(0, 7);
         put(i, j, sx == 0 ? 160 : sx == 1 ? 159 : $urandom_range(0, 170),
             sy == 0 ? 120 : sy == 1 ? 119 : $urandom_range(0, 125),
             $urandom_range(0, 7), with_last && j == len - 1);
      end
      bh[i] = 0;
      bn[i] = len;
   endtask

   task automatic step();
      logic [N-1:0]   r, l;
      logic [8*N-1:0] vx;
      logic [7*N-1:0] vy;
      logic [3*N-1:0] vc;
      beat_t b;
      int acc, o, p;
      bit rel;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         if (gen_en && bh[i] == bn[i] && $urandom_range(0, 3) == 0)
            new_burst(i, $urandom_range(1, 12), $urandom_range(0, 3) != 0);
         else if (gen_en && bh[i] < bn[i] && $urandom_range(0, 40) == 0)
            bh[i] = bn[i];
      end
      r = '0; l = '0; vx = '0; vy = '0; vc = '0;
      for (int i = 0; i < N; i++)
         if (bh[i] < bn[i]) begin
            b = bq[i][bh[i]];
            r[i] = 1'b1;
            l[i] = b.last;
            vx[8*i +: 8] = b.x;
            vy[7*i +: 7] = b.y;
            vc[3*i +: 3] = b.c;
         end
      bus.req = r;
      bus.req_last = l;
      bus.req_x = vx;
      bus.req_y = vy;
      bus.req_colour = vc;
      acc = -1;
      if (m_owner < 0) begin
         e_plot = 0;
         p = -1;
         for (int k = 1; k <= N; k++)
            if (p < 0 && r[(m_ptr + k) % N]) p = (m_ptr + k) % N;
         m_owner = p;
         m_beats = 0;
      end else begin
         o = m_owner;
         if (r[o]) begin
            acc = o;
            b = bq[o][bh[o]];
            e_plot = (b.x < XM) && (b.y < YM);
            e_x = b.x;
            e_y = b.y;
            e_c = b.c;
            m_beats++;
            rel = b.last || m_beats == BM;
`ifdef VGA_PLOT_ARB_STATS_EN
            m_sb[o] = (m_sb[o] + 1) % 65536;
            if (!e_plot && m_sc < 65535) m_sc++;
`endif
         end else begin
            e_plot = 0;
            rel = 1;
         end
         if (rel) begin
            m_ptr = o;
            m_owner = -1;
         end
      end
      e_gnt = (m_owner < 0) ? '0 : N'(1) << m_owner;
      e_busy = m_owner >= 0;
      @(posedge clk);
      #1;
      chk("gnt", 32'(bus.gnt), 32'(e_gnt));
      chk("busy", 32'(bus.busy), 32'(e_busy));
      chk("plot", 32'(bus.plot), 32'(e_plot));
      chk("x", 32'(bus.x), 32'(e_x));
      chk("y", 32'(bus.y), 32'(e_y));
      chk("colour", 32'(bus.colour), 32'(e_c));
`ifdef VGA_PLOT_ARB_STATS_EN
      for (int i = 0; i < N; i++)
         chk("stat_beats", 32'(stat_beats[16*i +: 16]), 32'(m_sb[i]));
      chk("stat_clipped", 32'(stat_clipped), 32'(m_sc));
`endif
      if (acc >= 0) bh[acc]++;
   endtask

   initial begin
      bit seen;
      bus.req = '0;
      bus.req_last = '0;
      bus.req_x = '0;
      bus.req_y = '0;
      bus.req_colour = '0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_gnt", 32'(bus.gnt), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_plot", 32'(bus.plot), 32'd0);
      chk("rst_xyc", {17'd0, bus.x, bus.y}, 32'd0);
      reset = 1'b0;

      gen_en = 1;
      repeat (1500) step();

      // directed: reset arriving mid-burst must drop the port without a clock edge
      gen_en = 0;
      for (int i = 0; i < N; i++) bh[i] = bn[i];
      repeat (3) step();
      for (int j = 0; j < 6; j++) put(1, j, 20 + j, 30, 7, j == 5);
      bh[1] = 0;
      bn[1] = 6;
      seen = 0;
      for (int k = 0; k < 8 && !seen; k++) begin
         step();
         seen = bus.plot;
      end
      chk("midburst_plot_seen", 32'(seen), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("async_plot", 32'(bus.plot), 32'd0);
      chk("async_gnt", 32'(bus.gnt), 32'd0);
      chk("async_busy", 32'(bus.busy), 32'd0);
      bus.req = '0;
      bus.req_last = '0;
      model_reset();
      @(negedge clk);
      reset = 1'b0;

      // all requesting after reset: the first grant belongs to requester 0
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < 2; j++) put(i, j, 40 + i, 50 + j, i + 1, j == 1);
         bh[i] = 0;
         bn[i] = 2;
      end
      step();
      chk("first_gnt", 32'(bus.gnt), 32'd1);
      repeat (12) step();

      // clipping boundaries
      put(2, 0, 160, 5, 3, 0);
      put(2, 1, 10, 120, 4, 0);
      put(2, 2, 159, 119, 5, 1);
      bh[2] = 0;
      bn[2] = 3;
      repeat (6) step();
      chk("clip_last_x", 32'(bus.x), 32'd159);
      chk("clip_last_y", 32'(bus.y), 32'd119);

      gen_en = 1;
      repeat (1000) step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
